roi_raster_scan_gen: RTL and testbench
======================================

// Module: roi_raster_scan_gen
// PURPOSE
//  Parametrised successor to the frame raster counter. Walks a programmable rectangular region
//  of interest (ROI) inside an IMG_W x IMG_H frame, LANES pixels per beat, and emits row/col,
//  a pitched linear address, and SOL/EOL/SOF/EOF markers over a valid/ready handshake.
//  Sits between the filter control FSM (start/config) and the frame-buffer read port / line buffers.
// PARAMETERS
//  IMG_W   480  frame width in pixels
//  IMG_H   272  frame height in lines
//  ROW_W   9    row counter width
//  COL_W   9    column counter width
//  ADDR_W  17   address width; address arithmetic wraps modulo 2^ADDR_W
//  LANES   1    pixels per beat; one of 1, 2, 4
// PORTS
//  iClk         in   1       clock
//  iRst         in   1       synchronous reset, active-high
//  start        in   1       1-cycle pulse; samples cfg_* (honoured only in IDLE)
//  cfg_x0       in   COL_W   ROI first column
//  cfg_y0       in   ROW_W   ROI first row
//  cfg_w        in   COL_W   ROI width in pixels
//  cfg_h        in   ROW_W   ROI height in lines
//  cfg_base     in   ADDR_W  frame base address
//  cfg_pitch    in   ADDR_W  address stride per line
//  out_valid    out  1       beat valid
//  out_ready    in   1       consumer accepts beat
//  row          out  ROW_W   current row
//  col          out  COL_W   first column of beat
//  addr         out  ADDR_W  base + row*pitch + col
//  sol/eol      out  1       first/last beat of ROI line
//  sof/eof      out  1       first/last beat of ROI
//  busy         out  1       high in LOAD or RUN
//  cfg_err      out  1       1-cycle pulse: rejected configuration
//  frame_done   out  1       1-cycle pulse, cycle after final accepted beat
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0. Reset in any state returns to IDLE next edge; no done pulse.
//  - States: IDLE -> (start & cfg ok) LOAD -> RUN -> (last beat accepted) IDLE.
//  - IDLE + start: check w!=0, h!=0, w%LANES==0, x0+w<=IMG_W, y0+h<=IMG_H (compare at COL_W+1/ROW_W+1).
//    On any failure: cfg_err=1 next cycle, stay IDLE. On success: latch cfg into shadow registers.
//  - LOAD (1 cycle): line_base <= cfg_base + y0*pitch (the only multiply). out_valid=0.
//  - RUN: out_valid=1 from the first RUN cycle. Latency: start -> first valid = 2 cycles.
//  - Beat transfers when out_valid & out_ready. While valid & !ready, all outputs hold stable.
//  - Per transfer: col+=LANES, addr+=LANES. At line end: col=x0, row+=1,
//    line_base+=pitch, addr=line_base+pitch+x0.
//  - sol=(col==x0), eol=(col==x0+w-LANES), sof=sol & (row==y0), eof=eol & (row==y0+h-1);
//    combinational from registered state.
//  - Last beat (eof) accepted: next cycle out_valid=0, busy=0, frame_done=1, row/col/addr hold last values.
//  - start while busy: ignored, with no cfg_err. start in the same cycle as frame_done: accepted (state is IDLE).
//  - w==LANES and h==1: a single beat with sol=eol=sof=eof=1.
//  - cfg_* are don't-care outside the start cycle; the shadow registers isolate the scan.
// STRUCTURE
//  - Shared package raster_pkg: state encodings (IDLE/LOAD/RUN), LANES legality constant, and the
//    IMG_W/IMG_H defaults used by all raster blocks.
//  - One sub-module, roi_cfg_check: combinational legality check; output is cfg_ok.
//  - Top level: FSM, shadow registers, row/col counters, line_base/addr accumulators.
// TESTING
//  1. Defaults, ROI 0,0,480,272, pitch 480, base 0, ready=1 -> 130560 beats, addr 0..130559
//     contiguous, frame_done 1 cycle after the beat at addr 130559.
//  2. ROI x0=10 y0=5 w=4 h=2, pitch 512, base 0x100 -> addrs 0xB0A..0xB0D, 0xD0A..0xD0D;
//     sol on 0xB0A/0xD0A, eof on 0xD0D.
//  3. LANES=4, w=8 h=1 x0=0 -> 2 beats at col 0 and 4; w=6 -> cfg_err pulse, stays IDLE.
//  4. Random out_ready (~50%) on case 2 -> same address sequence; outputs stable across stalls.
//  5. x0=470 w=16 -> cfg_err=1, busy=0; a second start while busy in case 1 -> ignored, no error.
//  6. iRst asserted mid-RUN -> next cycle out_valid=0, busy=0, no frame_done; restart begins at sof.

Source files
------------

// File: rtl/raster_pkg.sv
// Shared definitions for the raster scan blocks: scan states, default frame
// geometry and the legal pixels-per-beat set.
package raster_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } raster_state_e;

  localparam int RASTER_IMG_W = 480;
  localparam int RASTER_IMG_H = 272;

  function automatic logic lanes_legal(input int lanes);
    return (lanes == 1) || (lanes == 2) || (lanes == 4);
  endfunction

endpackage

// File: rtl/roi_cfg_check.sv
// Combinational legality check of a requested ROI against the frame and lane width.
module roi_cfg_check
  import raster_pkg::*;
#(
  parameter int IMG_W = RASTER_IMG_W,
  parameter int IMG_H = RASTER_IMG_H,
  parameter int ROW_W = 9,
  parameter int COL_W = 9,
  parameter int LANES = 1
) (
  input  logic [COL_W-1:0] x0_i,
  input  logic [COL_W-1:0] w_i,
  input  logic [ROW_W-1:0] y0_i,
  input  logic [ROW_W-1:0] h_i,
  output logic             cfg_ok_o
);

  localparam logic [COL_W-1:0] LANE_MASK = COL_W'(LANES - 1);
  localparam logic [COL_W:0]   X_LIM     = (COL_W + 1)'(IMG_W);
  localparam logic [ROW_W:0]   Y_LIM     = (ROW_W + 1)'(IMG_H);
  localparam logic             LANES_OK  = lanes_legal(LANES);

  // One extra bit so x0+w / y0+h cannot wrap past the frame edge.
  logic [COL_W:0] x_end;
  logic [ROW_W:0] y_end;

  assign x_end = {1'b0, x0_i} + {1'b0, w_i};
  assign y_end = {1'b0, y0_i} + {1'b0, h_i};

  assign cfg_ok_o = LANES_OK
                  && (w_i != '0)
                  && (h_i != '0)
                  && ((w_i & LANE_MASK) == '0)
                  && (x_end <= X_LIM)
                  && (y_end <= Y_LIM);

endmodule

// File: rtl/roi_raster_scan_gen.sv
// ROI raster scan generator: walks a rectangle of the frame LANES pixels per beat and
// emits row/col, pitched address and line/frame markers over valid/ready.
module roi_raster_scan_gen
  import raster_pkg::*;
#(
  parameter int IMG_W  = RASTER_IMG_W,
  parameter int IMG_H  = RASTER_IMG_H,
  parameter int ROW_W  = 9,
  parameter int COL_W  = 9,
  parameter int ADDR_W = 17,
  parameter int LANES  = 1
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              start,
  input  logic [COL_W-1:0]  cfg_x0,
  input  logic [ROW_W-1:0]  cfg_y0,
  input  logic [COL_W-1:0]  cfg_w,
  input  logic [ROW_W-1:0]  cfg_h,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [ADDR_W-1:0] cfg_pitch,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ROW_W-1:0]  row,
  output logic [COL_W-1:0]  col,
  output logic [ADDR_W-1:0] addr,
  output logic              sol,
  output logic              eol,
  output logic              sof,
  output logic              eof,
  output logic              busy,
  output logic              cfg_err,
  output logic              frame_done
);

  raster_state_e     state_q;
  logic [COL_W-1:0]  x0_q, w_q, col_q;
  logic [ROW_W-1:0]  y0_q, h_q, row_q;
  logic [ADDR_W-1:0] base_q, pitch_q, line_base_q, addr_q;
  logic              cfg_err_q, frame_done_q;

  logic              cfg_ok;
  logic              run;
  logic              sol_c, eol_c, last_row_c;
  logic [COL_W:0]    eol_col;
  logic [ROW_W:0]    eof_row;
  logic [ADDR_W-1:0] y0_off;
  logic [ADDR_W-1:0] line_base_d;
  logic [COL_W-1:0]  col_d;
  logic [ADDR_W-1:0] addr_d;

  roi_cfg_check #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .ROW_W (ROW_W),
    .COL_W (COL_W),
    .LANES (LANES)
  ) u_cfg_check (
    .x0_i     (cfg_x0),
    .w_i      (cfg_w),
    .y0_i     (cfg_y0),
    .h_i      (cfg_h),
    .cfg_ok_o (cfg_ok)
  );

  // Single multiplier, only consumed in LOAD to seed the first line.
  assign y0_off      = ADDR_W'(y0_q) * pitch_q;
  assign line_base_d = line_base_q + pitch_q;
  assign col_d       = col_q + COL_W'(LANES);
  assign addr_d      = addr_q + ADDR_W'(LANES);

  assign eol_col    = {1'b0, x0_q} + {1'b0, w_q} - (COL_W + 1)'(LANES);
  assign eof_row    = {1'b0, y0_q} + {1'b0, h_q} - (ROW_W + 1)'(1);
  assign sol_c      = (col_q == x0_q);
  assign eol_c      = ({1'b0, col_q} == eol_col);
  assign last_row_c = ({1'b0, row_q} == eof_row);

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q      <= ST_IDLE;
      x0_q         <= '0;
      y0_q         <= '0;
      w_q          <= '0;
      h_q          <= '0;
      base_q       <= '0;
      pitch_q      <= '0;
      row_q        <= '0;
      col_q        <= '0;
      addr_q       <= '0;
      line_base_q  <= '0;
      cfg_err_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      cfg_err_q    <= 1'b0;
      frame_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              x0_q    <= cfg_x0;
              y0_q    <= cfg_y0;
              w_q     <= cfg_w;
              h_q     <= cfg_h;
              base_q  <= cfg_base;
              pitch_q <= cfg_pitch;
              state_q <= ST_LOAD;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          line_base_q <= base_q + y0_off;
          addr_q      <= base_q + y0_off + ADDR_W'(x0_q);
          row_q       <= y0_q;
          col_q       <= x0_q;
          state_q     <= ST_RUN;
        end
        ST_RUN: begin
          if (out_ready) begin
            if (eol_c && last_row_c) begin
              // Position registers keep the final beat after the frame ends.
              state_q      <= ST_IDLE;
              frame_done_q <= 1'b1;
            end else if (eol_c) begin
              col_q       <= x0_q;
              row_q       <= row_q + ROW_W'(1);
              line_base_q <= line_base_d;
              addr_q      <= line_base_d + ADDR_W'(x0_q);
            end else begin
              col_q  <= col_d;
              addr_q <= addr_d;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign run        = (state_q == ST_RUN);
  assign out_valid  = run;
  assign busy       = (state_q != ST_IDLE);
  assign row        = row_q;
  assign col        = col_q;
  assign addr       = addr_q;
  assign sol        = run && sol_c;
  assign eol        = run && eol_c;
  assign sof        = run && sol_c && (row_q == y0_q);
  assign eof        = run && eol_c && last_row_c;
  assign cfg_err    = cfg_err_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_roi_raster_scan_gen.sv
// Bench for roi_raster_scan_gen: a per-beat expectation queue built from the ROI
// geometry, checked every cycle, plus directed latency, error and reset cases.
module tb_roi_raster_scan_gen;

  localparam int ROW_W  = 9;
  localparam int COL_W  = 9;
  localparam int ADDR_W = 17;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, start, start4, out_ready, ready4;
  logic [COL_W-1:0]  cfg_x0, cfg_w;
  logic [ROW_W-1:0]  cfg_y0, cfg_h;
  logic [ADDR_W-1:0] cfg_base, cfg_pitch;

  logic              out_valid, sol, eol, sof, eof, busy, cfg_err, frame_done;
  logic [ROW_W-1:0]  row;
  logic [COL_W-1:0]  col;
  logic [ADDR_W-1:0] addr;

  logic              v4, sol4, eol4, sof4, eof4, busy4, err4, done4;
  logic [ROW_W-1:0]  row4;
  logic [COL_W-1:0]  col4;
  logic [ADDR_W-1:0] addr4;

  roi_raster_scan_gen #(.LANES(1)) u_dut (
    .iClk(clk), .iRst(rst), .start(start),
    .cfg_x0(cfg_x0), .cfg_y0(cfg_y0), .cfg_w(cfg_w), .cfg_h(cfg_h),
    .cfg_base(cfg_base), .cfg_pitch(cfg_pitch),
    .out_valid(out_valid), .out_ready(out_ready),
    .row(row), .col(col), .addr(addr),
    .sol(sol), .eol(eol), .sof(sof), .eof(eof),
    .busy(busy), .cfg_err(cfg_err), .frame_done(frame_done)
  );

  roi_raster_scan_gen #(.LANES(4)) u_dut4 (
    .iClk(clk), .iRst(rst), .start(start4),
    .cfg_x0(cfg_x0), .cfg_y0(cfg_y0), .cfg_w(cfg_w), .cfg_h(cfg_h),
    .cfg_base(cfg_base), .cfg_pitch(cfg_pitch),
    .out_valid(v4), .out_ready(ready4),
    .row(row4), .col(col4), .addr(addr4),
    .sol(sol4), .eol(eol4), .sof(sof4), .eof(eof4),
    .busy(busy4), .cfg_err(err4), .frame_done(done4)
  );

  typedef struct packed {
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
    logic [ADDR_W-1:0] addr;
    logic sol, eol, sof, eof;
  } beat_t;

  beat_t exp_q[$];
  beat_t cur, held, e;
  logic  prev_stall = 1'b0;
  logic  done_pend  = 1'b0;
  int    checks     = 0;
  int    failures   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected beats straight from the ROI definition: every line, every LANES-th column.
  task automatic push_frame(input int x0, input int y0, input int w, input int h,
                            input int base, input int pitch, input int lanes);
    beat_t b;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c += lanes) begin
        b.row  = ROW_W'(y0 + r);
        b.col  = COL_W'(x0 + c);
        b.addr = ADDR_W'(base + (y0 + r) * pitch + x0 + c);
        b.sol  = (c == 0);
        b.eol  = (c == w - lanes);
        b.sof  = b.sol && (r == 0);
        b.eof  = b.eol && (r == h - 1);
        exp_q.push_back(b);
      end
    end
  endtask

  always @(negedge clk) begin
    cur = {row, col, addr, sol, eol, sof, eof};
    if (rst) begin
      exp_q.delete();
      prev_stall = 1'b0;
      done_pend  = 1'b0;
    end else begin
      chk("frame_done", frame_done, done_pend);
      done_pend = 1'b0;
      if (prev_stall && out_valid) chk("stall_hold", cur, held);
      if (out_valid && out_ready) begin
        chk("beat_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("beat", cur, e);
          done_pend = e.eof;
        end
      end
      prev_stall = out_valid && !out_ready;
      held       = cur;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int x0, input int y0, input int w, input int h,
                         input int base, input int pitch);
    cfg_x0    = COL_W'(x0);
    cfg_y0    = ROW_W'(y0);
    cfg_w     = COL_W'(w);
    cfg_h     = ROW_W'(h);
    cfg_base  = ADDR_W'(base);
    cfg_pitch = ADDR_W'(pitch);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int max, input string name);
    int n = 0;
    while (frame_done !== 1'b1 && n < max) begin
      cyc(1);
      n++;
    end
    chk(name, frame_done, 1);
    chk({name, "_drained"}, exp_q.size(), 0);
  endtask

  int bad_cfg[4][4] = '{'{470, 0, 16, 1}, '{0, 0, 0, 1}, '{0, 270, 4, 3}, '{0, 0, 4, 0}};

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; start4 = 1'b0; out_ready = 1'b1; ready4 = 1'b1;
    set_cfg(0, 0, 0, 0, 0, 0);
    cyc(3);
    chk("reset_outputs", {out_valid, busy, sol, eol, sof, eof, cfg_err, frame_done, row, col, addr}, 0);
    rst = 1'b0;
    cyc(1);

    // Small ROI; model pinned against hand-computed addresses first.
    set_cfg(10, 5, 4, 2, 'h100, 512);
    push_frame(10, 5, 4, 2, 'h100, 512, 1);
    chk("model_first_addr", exp_q[0].addr, 'hB0A);
    chk("model_line2_addr", exp_q[4].addr, 'hD0A);
    chk("model_line2_sol", exp_q[4].sol, 1);
    chk("model_last_addr", exp_q[7].addr, 'hD0D);
    chk("model_last_eof", exp_q[7].eof, 1);
    pulse_start();
    chk("load_valid", out_valid, 0);
    chk("load_busy", busy, 1);
    cyc(1);
    chk("first_valid", out_valid, 1);
    chk("first_sof", sof, 1);
    chk("first_addr", addr, 'hB0A);
    wait_done(50, "roi_done");

    // Start in the frame_done cycle, then the same ROI under random back-pressure.
    push_frame(10, 5, 4, 2, 'h100, 512, 1);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    chk("start_on_done_busy", busy, 1);
    n = 0;
    while (frame_done !== 1'b1 && n < 500) begin
      out_ready = 1'($urandom_range(0, 1));
      cyc(1);
      n++;
    end
    chk("stall_done", frame_done, 1);
    chk("stall_drained", exp_q.size(), 0);
    out_ready = 1'b1;
    chk("hold_valid", out_valid, 0);
    chk("hold_busy", busy, 0);
    chk("hold_addr", addr, 'hD0D);
    chk("hold_col", col, 13);
    chk("hold_row", row, 6);

    // Rejected configurations.
    for (int i = 0; i < 4; i++) begin
      set_cfg(bad_cfg[i][0], bad_cfg[i][1], bad_cfg[i][2], bad_cfg[i][3], 0, 480);
      pulse_start();
      chk("cfg_err_pulse", cfg_err, 1);
      chk("cfg_err_busy", busy, 0);
      cyc(1);
      chk("cfg_err_clear", cfg_err, 0);
      chk("cfg_err_idle", busy, 0);
    end

    // ROI touching the right and bottom frame edges is legal.
    set_cfg(464, 271, 16, 1, 0, 480);
    push_frame(464, 271, 16, 1, 0, 480, 1);
    pulse_start();
    chk("edge_no_err", cfg_err, 0);
    wait_done(50, "edge_done");

    // Large contiguous ROI with an ignored start mid-frame.
    set_cfg(0, 0, 480, 120, 0, 480);
    push_frame(0, 0, 480, 120, 0, 480, 1);
    chk("model_big_row1", exp_q[480].addr, 480);
    chk("model_big_last", exp_q[57599].addr, 57599);
    pulse_start();
    cyc(100);
    set_cfg(470, 0, 16, 1, 0, 480);
    pulse_start();
    chk("busy_start_no_err", cfg_err, 0);
    chk("busy_start_busy", busy, 1);
    cyc(1);
    chk("busy_start_no_err2", cfg_err, 0);
    wait_done(60000, "big_done");
    chk("big_last_addr", addr, 57599);

    // Reset in the middle of a scan.
    set_cfg(10, 5, 4, 2, 'h100, 512);
    push_frame(10, 5, 4, 2, 'h100, 512, 1);
    pulse_start();
    cyc(3);
    rst = 1'b1;
    cyc(1);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", frame_done, 0);
    rst = 1'b0;
    cyc(2);
    chk("post_rst_done", frame_done, 0);
    push_frame(10, 5, 4, 2, 'h100, 512, 1);
    pulse_start();
    cyc(1);
    chk("restart_sof", sof, 1);
    chk("restart_addr", addr, 'hB0A);
    wait_done(50, "restart_done");

    // Four-lane instance.
    set_cfg(0, 0, 8, 1, 0, 480);
    start4 = 1'b1;
    cyc(1);
    start4 = 1'b0;
    chk("l4_load_valid", v4, 0);
    cyc(1);
    chk("l4_b0", {v4, col4, addr4, sol4, eol4, sof4, eof4}, {1'b1, 9'd0, 17'd0, 4'b1010});
    cyc(1);
    chk("l4_b1", {v4, col4, addr4, sol4, eol4, sof4, eof4}, {1'b1, 9'd4, 17'd4, 4'b0101});
    cyc(1);
    chk("l4_done", {v4, busy4, done4}, 3'b001);
    set_cfg(0, 0, 6, 1, 0, 480);
    start4 = 1'b1;
    cyc(1);
    start4 = 1'b0;
    chk("l4_err", {err4, busy4}, 2'b10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
